sum_accum: RTL and testbench

SUM_ACCUM -- requirements
Module: sum_accum

---
 rtl/sum_accum.sv | 76 +++++++
 tb/tb_sum_accum.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_accum.sv
// Group accumulator: sums up to GROUP unsigned samples (or fewer, when closed early by in_last)
// and holds the total and sample count behind a valid/ready handshake.
module sum_accum #(
  parameter int DATA_W = 10,
  parameter int GROUP  = 4,
  localparam int OUT_W = DATA_W + $clog2(GROUP),
  localparam int CNT_W = $clog2(GROUP) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_total,
  output logic [CNT_W-1:0]  out_count
);

  localparam logic [0:0] ST_ACC  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]       state;
  logic             ready_en;
  logic [OUT_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             deliver;
  logic [OUT_W-1:0] sum_next;
  logic [CNT_W-1:0] cnt_next;
  logic             closing;

  // ready_en keeps in_ready low during reset and until the first clock edge afterwards
  assign in_ready  = ready_en & ((state == ST_ACC) | out_ready);
  assign out_valid = (state == ST_HOLD);

  assign accept  = in_valid & in_ready;
  assign deliver = out_valid & out_ready;

  // acc and cnt are always zero in HOLD, so one datapath serves both the
  // ordinary accept and the deliver-plus-accept that starts a new group
  assign sum_next = acc + OUT_W'(in_sum);
  assign cnt_next = cnt + 1'b1;
  assign closing  = in_last | (cnt_next == CNT_W'(GROUP));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ACC;
      ready_en  <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      out_total <= '0;
      out_count <= '0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        if (closing) begin
          out_total <= sum_next;
          out_count <= cnt_next;
          acc       <= '0;
          cnt       <= '0;
          state     <= ST_HOLD;
        end else begin
          acc   <= sum_next;
          cnt   <= cnt_next;
          state <= ST_ACC;
        end
      end else if (deliver) begin
        state <= ST_ACC;
      end
    end
  end

endmodule

// File: tb/tb_sum_accum.sv
// Directed self-checking bench for sum_accum at default parameters (DATA_W=10, GROUP=4).
module tb_sum_accum;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_sum;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_total;
  logic [2:0]  out_count;

  int checks;
  int errors;

  sum_accum dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_total (out_total),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one sample at the falling edge; it is taken on the following rising edge
  task automatic send(input logic [9:0] data, input logic last);
    @(negedge clk);
    in_valid = 1'b1;
    in_sum   = data;
    in_last  = last;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_sum   = '0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_total !== 12'd0 || out_count !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got rdy=%b vld=%b tot=%0d cnt=%0d expected 0 0 0 0",
               in_ready, out_valid, out_total, out_count);
    end
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_over_edge got rdy=%b vld=%b expected 0 0", in_ready, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ready_after_reset got rdy=%b vld=%b expected 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_full_group();
    out_ready = 1'b1;
    send(10'd20, 1'b0);
    send(10'd218, 1'b0);
    send(10'd1020, 1'b0);
    send(10'd1, 1'b0);
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_total !== 12'd1259 || out_count !== 3'd4) begin
      errors++;
      $display("[TB] FAIL full_group got vld=%b tot=%0d cnt=%0d expected 1 1259 4",
               out_valid, out_total, out_count);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_group_delivered got vld=%b expected 0", out_valid);
    end
  endtask

  task automatic test_max_group();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(10'd1023, 1'b0);
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_total !== 12'd4092 || out_count !== 3'd4) begin
      errors++;
      $display("[TB] FAIL max_group got vld=%b tot=%0d cnt=%0d expected 1 4092 4",
               out_valid, out_total, out_count);
    end
  endtask

  task automatic test_early_close();
    out_ready = 1'b1;
    @(negedge clk);
    send(10'd20, 1'b0);
    send(10'd218, 1'b1);
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_total !== 12'd238 || out_count !== 3'd2) begin
      errors++;
      $display("[TB] FAIL early_close got vld=%b tot=%0d cnt=%0d expected 1 238 2",
               out_valid, out_total, out_count);
    end
    send(10'd3, 1'b1);
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_total !== 12'd3 || out_count !== 3'd1) begin
      errors++;
      $display("[TB] FAIL early_close_next got vld=%b tot=%0d cnt=%0d expected 1 3 1",
               out_valid, out_total, out_count);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 1'b0;
    send(10'd1, 1'b0);
    send(10'd2, 1'b0);
    send(10'd3, 1'b0);
    send(10'd4, 1'b0);
    // Junk sample offered while held must be refused
    @(negedge clk);
    in_valid = 1'b1;
    in_sum   = 10'd999;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_total !== 12'd10 || out_count !== 3'd4) begin
        errors++;
        $display("[TB] FAIL backpressure_hold cycle %0d got vld=%b rdy=%b tot=%0d cnt=%0d expected 1 0 10 4",
                 i, out_valid, in_ready, out_total, out_count);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sum    = 10'd7;
    in_last   = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL backpressure_release got rdy=%b vld=%b expected 1 1", in_ready, out_valid);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL backpressure_after_deliver got vld=%b expected 0", out_valid);
    end
    in_sum = 10'd1;
    @(posedge clk);
    send(10'd1, 1'b0);
    send(10'd1, 1'b0);
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_total !== 12'd10 || out_count !== 3'd4) begin
      errors++;
      $display("[TB] FAIL backpressure_next_group got vld=%b tot=%0d cnt=%0d expected 1 10 4",
               out_valid, out_total, out_count);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sum    = 10'd9;
    in_last   = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_total !== 12'd9 || out_count !== 3'd1 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL back_to_back_first got vld=%b tot=%0d cnt=%0d rdy=%b expected 1 9 1 1",
               out_valid, out_total, out_count, in_ready);
    end
    in_sum = 10'd11;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_total !== 12'd11 || out_count !== 3'd1) begin
      errors++;
      $display("[TB] FAIL back_to_back_second got vld=%b tot=%0d cnt=%0d expected 1 11 1",
               out_valid, out_total, out_count);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL back_to_back_drain got vld=%b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_group();
    out_ready = 1'b1;
    send(10'd100, 1'b0);
    send(10'd200, 1'b0);
    idle();
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_group_async got rdy=%b vld=%b expected 0 0", in_ready, out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) send(10'd5, 1'b0);
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_total !== 12'd20 || out_count !== 3'd4) begin
      errors++;
      $display("[TB] FAIL reset_mid_group got vld=%b tot=%0d cnt=%0d expected 1 20 4",
               out_valid, out_total, out_count);
    end
    // A held, undelivered result is also dropped by reset
    out_ready = 1'b0;
    @(negedge clk);
    send(10'd50, 1'b1);
    idle();
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_total !== 12'd0 || out_count !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_held_result got vld=%b tot=%0d cnt=%0d expected 0 0 0",
               out_valid, out_total, out_count);
    end
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_gapped();
    logic [9:0] samples [4];
    int gap;
    samples[0] = 10'd3;
    samples[1] = 10'd4;
    samples[2] = 10'd5;
    samples[3] = 10'd6;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(samples[i], 1'b0);
      if (i < 3) begin
        gap = $urandom_range(1, 3);
        for (int g = 0; g < gap; g++) begin
          idle();
          in_sum  = 10'd777;
          in_last = 1'b1;
        end
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("[TB] FAIL gapped_partial after sample %0d got vld=%b expected 0", i, out_valid);
        end
      end
    end
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_total !== 12'd18 || out_count !== 3'd4) begin
      errors++;
      $display("[TB] FAIL gapped got vld=%b tot=%0d cnt=%0d expected 1 18 4",
               out_valid, out_total, out_count);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_full_group();
    test_max_group();
    test_early_close();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_group();
    test_gapped();
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
